// File: rtl/spike_weight_accum.sv
// Synaptic integration front end for one weight-BRAM read port: issues one read per set
// spike bit, absorbs the read latency, and sums the returned signed weights with saturation.
module spike_weight_accum #(
    parameter int N_IN   = 64,
    parameter int ADDR_W = 13,
    parameter int DATA_W = 33,
    parameter int RD_LAT = 2,
    parameter int ACC_W  = 40
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [N_IN-1:0]          spikes,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic signed [ACC_W-1:0]  threshold,
    output logic [ADDR_W-1:0]        addr,
    output logic                     addr_valid,
    input  logic signed [DATA_W-1:0] rd_data,
    output logic                     busy,
    output logic                     done,
    output logic signed [ACC_W-1:0]  acc,
    output logic                     fire
);

    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_e;

    state_e                   state_q;
    logic [N_IN-1:0]          mask_q, mask_d;
    logic [ADDR_W-1:0]        base_q, addr_q;
    logic signed [ACC_W-1:0]  thr_q, acc_q, acc_d;
    logic [RD_LAT-1:0]        pipe_q;
    logic [CNT_W-1:0]         drain_q;
    logic                     fire_q;
    logic [IDX_W-1:0]         idx;
    logic                     issue;
    logic [ACC_W:0]           sum;

    // Priority pick of the lowest set bit; scanning downward lets the lowest index win.
    always_comb begin
        idx = '0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (mask_q[i]) idx = IDX_W'(i);
        end
    end

    always_comb begin
        issue  = (state_q == SCAN) && (|mask_q);
        mask_d = mask_q;
        if (issue) mask_d[idx] = 1'b0;
    end

    // One guard bit catches signed overflow; a clamp is applied term by term, so it never sticks.
    always_comb begin
        sum   = {acc_q[ACC_W-1], acc_q} + {{(ACC_W + 1 - DATA_W){rd_data[DATA_W-1]}}, rd_data};
        acc_d = acc_q;
        if (pipe_q[RD_LAT-1]) begin
            if (sum[ACC_W] != sum[ACC_W-1])
                acc_d = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
            else
                acc_d = sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= '0;
            base_q  <= '0;
            thr_q   <= '0;
            addr_q  <= '0;
            acc_q   <= '0;
            pipe_q  <= '0;
            drain_q <= '0;
            fire_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking updates let every register see this cycle's values, and the
            // later acc_q assignment in IDLE deliberately overrides the accumulate path.
            pipe_q <= (pipe_q << 1) | RD_LAT'(issue);
            acc_q  <= acc_d;
            if (issue) addr_q <= addr;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mask_q  <= spikes;
                        base_q  <= base_addr;
                        thr_q   <= threshold;
                        acc_q   <= '0;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    mask_q <= mask_d;
                    if (mask_d == '0) begin
                        drain_q <= CNT_W'(RD_LAT - 1);
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_q == '0) begin
                        fire_q  <= (acc_d >= thr_q);
                        state_q <= DONE;
                    end else begin
                        drain_q <= drain_q - CNT_W'(1);
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outside an issuing cycle the address bus holds the last issued read.
    assign addr       = issue ? (base_q + ADDR_W'(idx)) : addr_q;
    assign addr_valid = issue;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign acc        = acc_q;
    assign fire       = fire_q;

endmodule

// File: tb/tb_spike_weight_accum.sv
// Directed bench for spike_weight_accum with a 2-cycle BRAM model and a 34-bit accumulator.
module tb_spike_weight_accum;

    localparam int ACC_W = 34;

    logic        clk, rst, start;
    logic [63:0] spikes;
    logic [12:0] base_addr;
    logic [33:0] threshold;
    logic [12:0] addr;
    logic        addr_valid;
    logic [32:0] rd_data;
    logic        busy, done;
    logic [33:0] acc;
    logic        fire;

    logic [32:0] mem [8192];
    logic [32:0] d1, d2;

    int vectors    = 0;
    int miscompares = 0;
    int done_n;
    int got_addrs [$];
    int got_cycs  [$];
    int dn_cnt, dn_first, dn_second;

    spike_weight_accum #(.ACC_W(ACC_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .spikes     (spikes),
        .base_addr  (base_addr),
        .threshold  (threshold),
        .addr       (addr),
        .addr_valid (addr_valid),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done),
        .acc        (acc),
        .fire       (fire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-stage read pipe: address in cycle c, data in cycle c+2.
    always @(posedge clk) begin
        d1 <= mem[addr];
        d2 <= d1;
    end
    assign rd_data = d2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulses start for one cycle, then records issued addresses and the done cycle (offset from T).
    task automatic run_one(input logic [63:0] sp, input logic [12:0] ba, input logic [33:0] th);
        @(negedge clk);
        spikes = sp; base_addr = ba; threshold = th; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got_addrs.delete();
        got_cycs.delete();
        done_n = 0;
        for (int n = 1; n <= 200; n++) begin
            if (addr_valid) begin
                got_addrs.push_back(int'(addr));
                got_cycs.push_back(n);
            end
            if (done) begin
                done_n = n;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; spikes = '0; base_addr = '0; threshold = '0;
        for (int i = 0; i < 8192; i++) mem[i] = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr_valid", addr_valid, 0);
        chk("rst_addr", addr, 0);
        chk("rst_acc", acc, 0);
        chk("rst_fire", fire, 0);
        rst = 1'b0;

        // Single spike
        mem[105] = 33'd7;
        run_one(64'h20, 13'd100, 34'd7);
        chk("t1_done_cycle", done_n, 4);
        chk("t1_n_addrs", got_addrs.size(), 1);
        chk("t1_addr0", got_addrs[0], 105);
        chk("t1_addr0_cycle", got_cycs[0], 1);
        chk("t1_acc", acc, 7);
        chk("t1_fire", fire, 1);
        @(negedge clk);
        chk("t1_hold_acc", acc, 7);
        chk("t1_hold_fire", fire, 1);
        chk("t1_hold_busy", busy, 0);
        chk("t1_hold_done", done, 0);

        // Multiple spikes, ascending order, negative weight
        mem[0] = 33'd10; mem[3] = 33'h1_FFFF_FFFC; mem[63] = 33'd20;
        run_one(64'h8000_0000_0000_0009, 13'd0, 34'd27);
        chk("t2_done_cycle", done_n, 6);
        chk("t2_n_addrs", got_addrs.size(), 3);
        chk("t2_addr0", got_addrs[0], 0);
        chk("t2_addr1", got_addrs[1], 3);
        chk("t2_addr2", got_addrs[2], 63);
        chk("t2_addr2_cycle", got_cycs[2], 3);
        chk("t2_acc", acc, 26);
        chk("t2_fire", fire, 0);

        // Empty spike vector, both sides of a zero sum
        run_one(64'h0, 13'd500, 34'd0);
        chk("t3a_done_cycle", done_n, 4);
        chk("t3a_n_addrs", got_addrs.size(), 0);
        chk("t3a_acc", acc, 0);
        chk("t3a_fire", fire, 1);
        run_one(64'h0, 13'd500, 34'd1);
        chk("t3b_done_cycle", done_n, 4);
        chk("t3b_fire", fire, 0);

        // Address wrap-around
        mem[8191] = 33'd1; mem[0] = 33'd2; mem[1] = 33'd3;
        run_one(64'hE, 13'd8190, 34'h3_FFFF_FFFF);
        chk("t3c_done_cycle", done_n, 6);
        chk("t3c_addr0", got_addrs[0], 8191);
        chk("t3c_addr1", got_addrs[1], 0);
        chk("t3c_addr2", got_addrs[2], 1);
        chk("t3c_acc", acc, 6);
        chk("t3c_fire", fire, 1);

        // Positive saturation, full vector
        for (int i = 0; i < 64; i++) mem[2000 + i] = 33'h0_FFFF_FFFF;
        run_one({64{1'b1}}, 13'd2000, 34'h1_FFFF_FFFF);
        chk("t4a_done_cycle", done_n, 67);
        chk("t4a_n_addrs", got_addrs.size(), 64);
        chk("t4a_last_addr", got_addrs[63], 2063);
        chk("t4a_acc", acc, 34'h1_FFFF_FFFF);
        chk("t4a_fire", fire, 1);

        // Clamp is not sticky: saturate, then subtract 5
        for (int i = 0; i < 63; i++) mem[3000 + i] = 33'h0_FFFF_FFFF;
        mem[3063] = 33'h1_FFFF_FFFB;
        run_one({64{1'b1}}, 13'd3000, 34'h1_FFFF_FFFF);
        chk("t4b_acc", acc, 34'h1_FFFF_FFFA);
        chk("t4b_fire", fire, 0);

        // Negative saturation: second term lands exactly on the minimum, third clamps
        for (int i = 0; i < 3; i++) mem[4000 + i] = 33'h1_0000_0000;
        run_one(64'h7, 13'd4000, 34'h2_0000_0000);
        chk("t4c_done_cycle", done_n, 6);
        chk("t4c_acc", acc, 34'h2_0000_0000);
        chk("t4c_fire", fire, 1);

        // Start held high through a run
        mem[14] = 33'd1; mem[15] = 33'd2; mem[16] = 33'd3;
        dn_cnt = 0; dn_first = 0; dn_second = 0;
        @(negedge clk);
        spikes = 64'h70; base_addr = 13'd10; threshold = 34'd6; start = 1'b1;
        @(negedge clk);
        for (int n = 1; n <= 20; n++) begin
            if (done) begin
                dn_cnt++;
                if (dn_cnt == 1) begin
                    dn_first = n;
                    chk("t5_first_acc", acc, 6);
                end else begin
                    dn_second = n;
                end
            end
            if (n == 8) begin
                chk("t5_restart_busy", busy, 1);
                chk("t5_restart_acc", acc, 0);
                chk("t5_restart_addr", addr, 14);
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk("t5_done_pulses", dn_cnt, 2);
        chk("t5_first_done", dn_first, 6);
        chk("t5_second_done", dn_second, 13);
        chk("t5_acc", acc, 6);
        chk("t5_fire", fire, 1);

        // Asynchronous reset during DRAIN
        mem[20] = 33'd50; mem[21] = 33'd60; mem[22] = 33'd9;
        @(negedge clk);
        spikes = 64'h3; base_addr = 13'd20; threshold = 34'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_pre_busy", busy, 1);
        chk("t6_pre_acc", acc, 50);
        rst = 1'b1;
        #1;
        chk("t6_rst_addr", addr, 0);
        chk("t6_rst_addr_valid", addr_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_acc", acc, 0);
        chk("t6_rst_fire", fire, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_post_acc", acc, 0);
        chk("t6_post_busy", busy, 0);
        run_one(64'h4, 13'd20, 34'd9);
        chk("t6_fresh_done_cycle", done_n, 4);
        chk("t6_fresh_addr0", got_addrs[0], 22);
        chk("t6_fresh_acc", acc, 9);
        chk("t6_fresh_fire", fire, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
